// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit core:
// opcodes, instruction field positions and the ID/EX bundle.
package risc16_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 4;

   localparam logic [3:0] OP_ADDI  = 4'h8;
   localparam logic [3:0] OP_LOAD  = 4'h9;
   localparam logic [3:0] OP_STORE = 4'hA;
   localparam logic [3:0] OP_BEQ   = 4'hB;
   localparam logic [3:0] OP_NOP   = 4'hF;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int RS1_HI = 7;
   localparam int RS1_LO = 4;
   localparam int RS2_HI = 3;
   localparam int RS2_LO = 0;

   typedef struct packed {
      logic [3:0]        op;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] op_a;
      logic [DATA_W-1:0] op_b;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic              wr_rd;
   } id_ex_t;

   function automatic logic [DATA_W-1:0] sext_imm4(
      input logic [3:0] v
   );
      return {{(DATA_W-4){v[3]}}, v};
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand resolver for one source register:
// picks the youngest in-flight result, flags load-use.
module fwd_mux #(
   parameter int DATA_W = risc16_pkg::DATA_W,
   parameter int REG_AW = risc16_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] src_addr,
   input  logic              src_used,
   input  logic              exf_en,
   input  logic [REG_AW-1:0] exf_addr,
   input  logic [DATA_W-1:0] exf_data,
   input  logic              exf_is_load,
   input  logic              memf_en,
   input  logic [REG_AW-1:0] memf_addr,
   input  logic [DATA_W-1:0] memf_data,
   input  logic              wbf_en,
   input  logic [REG_AW-1:0] wbf_addr,
   input  logic [DATA_W-1:0] wbf_data,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] operand,
   output logic              load_hit
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   assign ex_hit  = src_used & exf_en  & (exf_addr  == src_addr);
   assign mem_hit = src_used & memf_en & (memf_addr == src_addr);
   assign wb_hit  = src_used & wbf_en  & (wbf_addr  == src_addr);

   // A load in EX has no data yet; the stage must wait one cycle.
   assign load_hit = ex_hit & exf_is_load;

   // Youngest producer wins: EX, then MEM, then the write port.
   always_comb begin
      operand = rf_data;
      if (ex_hit) begin
         operand = exf_data;
      end else if (mem_hit) begin
         operand = memf_data;
      end else if (wb_hit) begin
         operand = wbf_data;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: decode, forwarding,
// load-use stall and the ID/EX register.
module operand_fetch #(
   parameter int DATA_W = risc16_pkg::DATA_W,
   parameter int REG_AW = risc16_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [15:0]       if_instr,
   input  logic [DATA_W-1:0] if_pc,
   output logic              id_ready,
   output logic [REG_AW-1:0] rf_rd_addr1,
   output logic [REG_AW-1:0] rf_rd_addr2,
   input  logic [DATA_W-1:0] rf_rd_data1,
   input  logic [DATA_W-1:0] rf_rd_data2,
   input  logic              exf_en,
   input  logic [REG_AW-1:0] exf_addr,
   input  logic [DATA_W-1:0] exf_data,
   input  logic              exf_is_load,
   input  logic              memf_en,
   input  logic [REG_AW-1:0] memf_addr,
   input  logic [DATA_W-1:0] memf_data,
   input  logic              wbf_en,
   input  logic [REG_AW-1:0] wbf_addr,
   input  logic [DATA_W-1:0] wbf_data,
   input  logic              flush,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [3:0]        ex_op,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc,
   output logic              ex_wr_rd
);

   import risc16_pkg::*;

   logic [3:0]        op;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;

   logic use_a;
   logic use_b;
   logic wr_rd;
   logic sel_rd_b;

   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic              hit_a;
   logic              hit_b;
   logic              stall;
   logic              load_en;

   logic   ex_valid_d;
   logic   ex_valid_q;
   id_ex_t id_ex_d;
   id_ex_t id_ex_q;

   assign op  = if_instr[OP_HI:OP_LO];
   assign rd  = if_instr[RD_HI:RD_LO];
   assign rs1 = if_instr[RS1_HI:RS1_LO];
   assign rs2 = if_instr[RS2_HI:RS2_LO];

   // Which sources each opcode reads, and whether it writes rd.
   always_comb begin
      use_a    = 1'b0;
      use_b    = 1'b0;
      wr_rd    = 1'b0;
      sel_rd_b = 1'b0;
      unique case (1'b1)
         (op < OP_ADDI): begin
            use_a = 1'b1;
            use_b = 1'b1;
            wr_rd = 1'b1;
         end
         (op == OP_ADDI),
         (op == OP_LOAD): begin
            use_a = 1'b1;
            wr_rd = 1'b1;
         end
         (op == OP_STORE),
         (op == OP_BEQ): begin
            use_a    = 1'b1;
            use_b    = 1'b1;
            sel_rd_b = 1'b1;
         end
         (op == OP_NOP): begin
         end
         default: begin
         end
      endcase
   end

   // STORE data and BEQ compare operand sit in the rd field.
   assign rf_rd_addr1 = rs1;
   assign rf_rd_addr2 = sel_rd_b ? rd : rs2;

   fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_a (
      .src_addr    (rf_rd_addr1),
      .src_used    (use_a),
      .exf_en      (exf_en),
      .exf_addr    (exf_addr),
      .exf_data    (exf_data),
      .exf_is_load (exf_is_load),
      .memf_en     (memf_en),
      .memf_addr   (memf_addr),
      .memf_data   (memf_data),
      .wbf_en      (wbf_en),
      .wbf_addr    (wbf_addr),
      .wbf_data    (wbf_data),
      .rf_data     (rf_rd_data1),
      .operand     (opnd_a),
      .load_hit    (hit_a)
   );

   fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_b (
      .src_addr    (rf_rd_addr2),
      .src_used    (use_b),
      .exf_en      (exf_en),
      .exf_addr    (exf_addr),
      .exf_data    (exf_data),
      .exf_is_load (exf_is_load),
      .memf_en     (memf_en),
      .memf_addr   (memf_addr),
      .memf_data   (memf_data),
      .wbf_en      (wbf_en),
      .wbf_addr    (wbf_addr),
      .wbf_data    (wbf_data),
      .rf_data     (rf_rd_data2),
      .operand     (opnd_b),
      .load_hit    (hit_b)
   );

   assign stall   = hit_a | hit_b;
   assign load_en = flush | ~ex_valid_q | ex_ready;
   assign id_ready = flush | (~stall & (~ex_valid_q | ex_ready));

   // Next ID/EX state: flush kills, stall bubbles, else capture.
   always_comb begin
      ex_valid_d = ex_valid_q;
      id_ex_d    = id_ex_q;
      if (load_en) begin
         ex_valid_d = if_valid & ~stall & ~flush;
         if (ex_valid_d) begin
            id_ex_d.op    = op;
            id_ex_d.rd    = rd;
            id_ex_d.op_a  = opnd_a;
            id_ex_d.op_b  = opnd_b;
            id_ex_d.imm   = sext_imm4(if_instr[RS2_HI:RS2_LO]);
            id_ex_d.pc    = if_pc;
            id_ex_d.wr_rd = wr_rd;
         end
      end
   end

   // ID/EX pipeline register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         id_ex_q    <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         id_ex_q    <= id_ex_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_op    = id_ex_q.op;
   assign ex_rd    = id_ex_q.rd;
   assign ex_op_a  = id_ex_q.op_a;
   assign ex_op_b  = id_ex_q.op_b;
   assign ex_imm   = id_ex_q.imm;
   assign ex_pc    = id_ex_q.pc;
   assign ex_wr_rd = id_ex_q.wr_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: accepted
// instructions queue expected bundles, EX pops them.
module tb_operand_fetch;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [15:0] pc;
      logic        wr;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready;
   logic [3:0]  rf_rd_addr1;
   logic [3:0]  rf_rd_addr2;
   logic [15:0] rf_rd_data1;
   logic [15:0] rf_rd_data2;
   logic        exf_en;
   logic [3:0]  exf_addr;
   logic [15:0] exf_data;
   logic        exf_is_load;
   logic        memf_en;
   logic [3:0]  memf_addr;
   logic [15:0] memf_data;
   logic        wbf_en;
   logic [3:0]  wbf_addr;
   logic [15:0] wbf_data;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  ex_op;
   logic [3:0]  ex_rd;
   logic [15:0] ex_op_a;
   logic [15:0] ex_op_b;
   logic [15:0] ex_imm;
   logic [15:0] ex_pc;
   logic        ex_wr_rd;

   logic [15:0] rf [16];
   exp_t        sb [$];
   exp_t        cur_exp;
   int          checks = 0;
   int          fails  = 0;

   assign rf_rd_data1 = rf[rf_rd_addr1];
   assign rf_rd_data2 = rf[rf_rd_addr2];

   operand_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .id_ready    (id_ready),
      .rf_rd_addr1 (rf_rd_addr1),
      .rf_rd_addr2 (rf_rd_addr2),
      .rf_rd_data1 (rf_rd_data1),
      .rf_rd_data2 (rf_rd_data2),
      .exf_en      (exf_en),
      .exf_addr    (exf_addr),
      .exf_data    (exf_data),
      .exf_is_load (exf_is_load),
      .memf_en     (memf_en),
      .memf_addr   (memf_addr),
      .memf_data   (memf_data),
      .wbf_en      (wbf_en),
      .wbf_addr    (wbf_addr),
      .wbf_data    (wbf_data),
      .flush       (flush),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_op       (ex_op),
      .ex_rd       (ex_rd),
      .ex_op_a     (ex_op_a),
      .ex_op_b     (ex_op_b),
      .ex_imm      (ex_imm),
      .ex_pc       (ex_pc),
      .ex_wr_rd    (ex_wr_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(
      input logic [15:0] instr,
      input logic [15:0] pc,
      input logic [15:0] a,
      input logic [15:0] b,
      input logic [15:0] imm,
      input logic        wr
   );
      if_valid    = 1'b1;
      if_instr    = instr;
      if_pc       = pc;
      cur_exp.op  = instr[15:12];
      cur_exp.rd  = instr[11:8];
      cur_exp.a   = a;
      cur_exp.b   = b;
      cur_exp.imm = imm;
      cur_exp.pc  = pc;
      cur_exp.wr  = wr;
   endtask

   task automatic idle();
      if_valid = 1'b0;
      if_instr = 16'hF000;
   endtask

   // Scoreboard: pop on EX handshake, drop on flush, push on accept.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (ex_valid && flush) begin
            check("sb_flush_head", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) e = sb.pop_front();
         end else if (ex_valid && ex_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("ex_op", 32'(ex_op), 32'(e.op));
               check("ex_rd", 32'(ex_rd), 32'(e.rd));
               check("ex_op_a", 32'(ex_op_a), 32'(e.a));
               check("ex_op_b", 32'(ex_op_b), 32'(e.b));
               check("ex_imm", 32'(ex_imm), 32'(e.imm));
               check("ex_pc", 32'(ex_pc), 32'(e.pc));
               check("ex_wr_rd", 32'(ex_wr_rd), 32'(e.wr));
            end
         end
         if (if_valid && id_ready && !flush) sb.push_back(cur_exp);
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 16'h0100 + 16'(i);
      rf[1] = 16'h0005;
      rf[2] = 16'h0007;
      rst_n = 1'b0;
      flush = 1'b0;
      ex_ready = 1'b1;
      exf_en = 1'b0; exf_addr = '0; exf_data = '0; exf_is_load = 1'b0;
      memf_en = 1'b0; memf_addr = '0; memf_data = '0;
      wbf_en = 1'b0; wbf_addr = '0; wbf_data = '0;
      send(16'h0312, 16'h0010, 16'd5, 16'd7, 16'h0002, 1'b1);

      // Reset holds the register clear despite a valid input.
      tick();
      tick();
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_op_a", 32'(ex_op_a), 32'd0);
      check("rst_pc", 32'(ex_pc), 32'd0);

      // ADD r3,r1,r2 after reset: one-cycle latency.
      rst_n = 1'b1;
      #1 check("add_ready", 32'(id_ready), 32'd1);
      tick();
      check("add_latency", 32'(ex_valid), 32'd1);
      idle();
      tick();

      // Forward priority on ADD r4,r1,r1.
      exf_en = 1'b1;  exf_addr = 4'd1;  exf_data = 16'h0011;
      memf_en = 1'b1; memf_addr = 4'd1; memf_data = 16'h0022;
      wbf_en = 1'b1;  wbf_addr = 4'd1;  wbf_data = 16'h0033;
      send(16'h0411, 16'h0020, 16'h0011, 16'h0011, 16'h0001, 1'b1);
      tick();
      exf_en = 1'b0;
      send(16'h0411, 16'h0022, 16'h0022, 16'h0022, 16'h0001, 1'b1);
      tick();
      memf_en = 1'b0;
      send(16'h0411, 16'h0024, 16'h0033, 16'h0033, 16'h0001, 1'b1);
      tick();
      wbf_en = 1'b0;
      send(16'h0411, 16'h0026, 16'h0005, 16'h0005, 16'h0001, 1'b1);
      tick();
      idle();
      tick();

      // Load-use: ADDI r5,r2,-1 behind a load of r2.
      exf_en = 1'b1; exf_addr = 4'd2; exf_data = 16'hDEAD;
      exf_is_load = 1'b1;
      send(16'h852F, 16'h0030, 16'h0042, 16'h010F, 16'hFFFF, 1'b1);
      #1 check("lu_stall_ready", 32'(id_ready), 32'd0);
      tick();
      check("lu_bubble", 32'(ex_valid), 32'd0);
      exf_en = 1'b0; exf_is_load = 1'b0;
      memf_en = 1'b1; memf_addr = 4'd2; memf_data = 16'h0042;
      #1 check("lu_ready_after", 32'(id_ready), 32'd1);
      tick();
      check("lu_valid", 32'(ex_valid), 32'd1);
      memf_en = 1'b0;
      idle();
      tick();

      // STORE r6 -> [r1+2], then NOP / reserved beside a load.
      send(16'hA612, 16'h0040, 16'h0005, 16'h0106, 16'h0002, 1'b0);
      #1 check("st_addr2", 32'(rf_rd_addr2), 32'd6);
      tick();
      exf_en = 1'b1; exf_addr = 4'd2; exf_is_load = 1'b1;
      send(16'hF322, 16'h0042, 16'h0007, 16'h0007, 16'h0002, 1'b0);
      #1 check("nop_no_stall", 32'(id_ready), 32'd1);
      tick();
      send(16'hC322, 16'h0044, 16'h0007, 16'h0007, 16'h0002, 1'b0);
      #1 check("rsv_no_stall", 32'(id_ready), 32'd1);
      tick();
      exf_en = 1'b0; exf_is_load = 1'b0;
      idle();
      tick();

      // Backpressure for three cycles, then release.
      send(16'h0712, 16'h0050, 16'h0005, 16'h0007, 16'h0002, 1'b1);
      tick();
      ex_ready = 1'b0;
      wbf_en = 1'b1; wbf_addr = 4'd1; wbf_data = 16'h0777;
      send(16'h0821, 16'h0052, 16'h0007, 16'h0005, 16'h0001, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1 check("bp_ready", 32'(id_ready), 32'd0);
         tick();
         check("bp_valid", 32'(ex_valid), 32'd1);
         check("bp_op_a", 32'(ex_op_a), 32'h0005);
         check("bp_pc", 32'(ex_pc), 32'h0050);
      end
      wbf_en = 1'b0;
      ex_ready = 1'b1;
      #1 check("bp_release_ready", 32'(id_ready), 32'd1);
      tick();
      idle();
      tick();

      // Flush while a load-use stall is pending.
      send(16'h0312, 16'h0060, 16'h0005, 16'h0007, 16'h0002, 1'b1);
      tick();
      exf_en = 1'b1; exf_addr = 4'd2; exf_is_load = 1'b1;
      flush = 1'b1;
      send(16'h852F, 16'h0062, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
      #1 check("fl_lu_ready", 32'(id_ready), 32'd1);
      tick();
      check("fl_lu_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;
      exf_en = 1'b0; exf_is_load = 1'b0;
      send(16'h0312, 16'h0064, 16'h0005, 16'h0007, 16'h0002, 1'b1);
      #1 check("fl_lu_accept", 32'(id_ready), 32'd1);
      tick();
      idle();
      tick();

      // Flush while execute is back-pressuring.
      send(16'h0312, 16'h0070, 16'h0005, 16'h0007, 16'h0002, 1'b1);
      tick();
      ex_ready = 1'b0;
      send(16'h0821, 16'h0072, 16'h0007, 16'h0005, 16'h0001, 1'b1);
      #1 check("fl_bp_ready0", 32'(id_ready), 32'd0);
      tick();
      flush = 1'b1;
      #1 check("fl_bp_ready1", 32'(id_ready), 32'd1);
      tick();
      check("fl_bp_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;
      ex_ready = 1'b1;
      send(16'h0512, 16'h0074, 16'h0005, 16'h0007, 16'h0002, 1'b1);
      #1 check("fl_bp_accept", 32'(id_ready), 32'd1);
      tick();
      idle();
      tick();
      tick();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
